// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared RAM-controller constants, arbiter state type and round-robin pointer helper
package ram_ctrl_pkg;
  localparam int RAM_BYTES = 4;
  localparam int BYTE_ADDR_W = 2;
  typedef enum logic [1:0] {IDLE, SEL, WAIT} arb_state_t;
  function automatic logic [2:0] ptr_inc(input logic [2:0] p, input int n);
    return (int'(p) >= n - 1) ? 3'd0 : p + 3'd1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit of eff_req at or after ptr with wrap
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] eff_req,
  input  logic [2:0]   ptr,
  output logic         found,
  output logic [2:0]   idx
);
  // scan from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    int j;
    found = 1'b0;
    idx = 3'd0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = (j >= N) ? j - N : j;
      if (eff_req[j]) begin
        found = 1'b1;
        idx = 3'(j);
      end
    end
  end
endmodule

// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: round-robin sharing of the 4-byte RAM mux read path; SETTLE_WAIT_EN adds a settle WAIT state
module ram_read_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int ID_W = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   addr,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rvalid,
  output logic [ID_W-1:0]        rid,
  output logic                   mux_s0,
  output logic                   mux_s1,
  output logic                   mux_e_n,
  input  logic [DATA_W-1:0]      mux_dout
);
  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_param
    $error("ram_read_arbiter: parameter out of range");
  end
  arb_state_t state;
  logic [2:0] ptr, cur_id, idx;
  logic found;
  logic [NUM_REQ-1:0] eff_req;
  logic [BYTE_ADDR_W-1:0] win_addr;
`ifdef SETTLE_WAIT_EN
  logic [3:0] cnt;
`endif
  assign eff_req = req & ~gnt;
  assign win_addr = addr[2*idx +: BYTE_ADDR_W];
  rr_pick #(.N(NUM_REQ)) u_pick (
    .eff_req(eff_req),
    .ptr(ptr),
    .found(found),
    .idx(idx)
  );
  // arbitration FSM: pick and latch in IDLE, hold the mux enabled, capture and pulse on the final edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 3'd0;
      cur_id <= 3'd0;
      gnt <= '0;
      rvalid <= 1'b0;
      rdata <= '0;
      rid <= '0;
      mux_s1 <= 1'b0;
      mux_s0 <= 1'b0;
      mux_e_n <= 1'b1;
`ifdef SETTLE_WAIT_EN
      cnt <= 4'd0;
`endif
    end else begin
      gnt <= '0;
      rvalid <= 1'b0;
      case (state)
        IDLE: if (found) begin
          {mux_s1, mux_s0} <= win_addr;
          cur_id <= idx;
          mux_e_n <= 1'b0;
          state <= SEL;
        end
`ifdef SETTLE_WAIT_EN
        SEL: begin
          cnt <= 4'(SETTLE_CYC - 1);
          state <= WAIT;
        end
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          rdata <= mux_dout;
          rid <= ID_W'(cur_id);
          rvalid <= 1'b1;
          gnt[cur_id] <= 1'b1;
          mux_e_n <= 1'b1;
          ptr <= ptr_inc(cur_id, NUM_REQ);
          state <= IDLE;
        end
`else
        SEL: begin
          rdata <= mux_dout;
          rid <= ID_W'(cur_id);
          rvalid <= 1'b1;
          gnt[cur_id] <= 1'b1;
          mux_e_n <= 1'b1;
          ptr <= ptr_inc(cur_id, NUM_REQ);
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_read_arbiter.sv
// tb_ram_read_arbiter: directed tests with a transaction-level reference model and per-cycle compare
module tb_ram_read_arbiter;
  localparam int N = 4;
`ifdef SETTLE_WAIT_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] addr = '0;
  logic [N-1:0] gnt;
  logic [7:0] rdata, mux_dout;
  logic rvalid, mux_s0, mux_s1, mux_e_n;
  logic [1:0] rid;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [7:0] byte_of(input logic [1:0] a);
    case (a)
      2'd0: return 8'h3C;
      2'd1: return 8'h5A;
      2'd2: return 8'hA5;
      default: return 8'hC3;
    endcase
  endfunction
  assign mux_dout = mux_e_n ? 8'h00 : byte_of({mux_s1, mux_s0});
  ram_read_arbiter #(.NUM_REQ(N), .DATA_W(8), .ID_W(2), .SETTLE_CYC(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .addr(addr),
    .gnt(gnt),
    .rdata(rdata),
    .rvalid(rvalid),
    .rid(rid),
    .mux_s0(mux_s0),
    .mux_s1(mux_s1),
    .mux_e_n(mux_e_n),
    .mux_dout(mux_dout)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input logic [N-1:0] eff, input int p);
    for (int k = 0; k < N; k++) if (eff[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  int m_ptr, m_busy, m_cur, w;
  logic [1:0] m_addr, e_rid, e_sel;
  logic e_rvalid, e_en_n;
  logic [N-1:0] e_gnt;
  logic [7:0] e_rdata;
  always_comb w = pick(req & ~e_gnt, m_ptr);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_busy <= 0; m_cur <= 0; m_addr <= 2'd0;
      e_rvalid <= 1'b0; e_en_n <= 1'b1; e_gnt <= '0; e_rid <= 2'd0; e_sel <= 2'd0; e_rdata <= 8'h00;
    end else begin
      e_rvalid <= 1'b0;
      e_gnt <= '0;
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          e_rvalid <= 1'b1;
          e_gnt <= N'(1) << m_cur;
          e_rid <= 2'(m_cur);
          e_rdata <= byte_of(m_addr);
          e_en_n <= 1'b1;
          m_ptr <= (m_cur + 1) % N;
        end
      end else if (w >= 0) begin
        m_cur <= w;
        m_addr <= addr[2*w +: 2];
        e_sel <= addr[2*w +: 2];
        m_busy <= LAT - 1;
        e_en_n <= 1'b0;
      end
    end
  end
  always @(negedge clk) if (chk_on) begin
    check("rvalid", 32'(rvalid), 32'(e_rvalid));
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("rid", 32'(rid), 32'(e_rid));
    check("rdata", 32'(rdata), 32'(e_rdata));
    check("mux_e_n", 32'(mux_e_n), 32'(e_en_n));
    check("sel", 32'({mux_s1, mux_s0}), 32'(e_sel));
  end
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic collect(input int n, input bit drop, output int ids[8], output int stamps[8], output logic [7:0] datas[8]);
    int c = 0;
    int got = 0;
    while (got < n && c < 100) begin
      @(negedge clk);
      c++;
      if (rvalid) begin
        ids[got] = int'(rid);
        stamps[got] = c;
        datas[got] = rdata;
        got++;
        if (drop) req[rid] = 1'b0;
      end
    end
    check("collect_count", 32'(got), 32'(n));
  endtask
  int ids[8], stamps[8];
  logic [7:0] datas[8];
  int k, lo, extra;
  logic [1:0] sel_seen;
  bit seen;
  logic [7:0] t1_data;
  logic [1:0] t1_rid;
  logic [N-1:0] t1_gnt;
  initial begin
    #1 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mux_e_n", 32'(mux_e_n), 32'd1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);
    check("rst_sel", 32'({mux_s1, mux_s0}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    req = 4'b0010;
    addr = 8'b0000_1000;
    k = 0; lo = 0; seen = 1'b0; sel_seen = 2'd0;
    while (!seen && k < 50) begin
      @(negedge clk);
      k++;
      if (!mux_e_n) begin lo++; sel_seen = {mux_s1, mux_s0}; end
      if (rvalid) begin
        seen = 1'b1; t1_data = rdata; t1_rid = rid; t1_gnt = gnt;
        req = '0;
      end
    end
    check("t1_latency", 32'(k), 32'(LAT));
    check("t1_en_low_cycles", 32'(lo), 32'(LAT - 1));
    check("t1_sel", 32'(sel_seen), 32'd2);
    check("t1_rdata", 32'(t1_data), 32'hA5);
    check("t1_rid", 32'(t1_rid), 32'd1);
    check("t1_gnt", 32'(t1_gnt), 32'b0010);
    extra = 0;
    repeat (6) begin @(negedge clk); extra += int'(rvalid); end
    check("t1_no_regrant", 32'(extra), 32'd0);
    do_reset();
    addr = 8'b01_10_00_11;
    req = 4'b1111;
    collect(5, 1'b0, ids, stamps, datas);
    req = '0;
    check("t2_id0", 32'(ids[0]), 32'd0);
    check("t2_id1", 32'(ids[1]), 32'd1);
    check("t2_id2", 32'(ids[2]), 32'd2);
    check("t2_id3", 32'(ids[3]), 32'd3);
    check("t2_id4", 32'(ids[4]), 32'd0);
    check("t2_first_lat", 32'(stamps[0]), 32'(LAT));
    for (int i = 1; i < 5; i++) check("t2_interval", 32'(stamps[i] - stamps[i-1]), 32'(LAT));
    check("t2_data0", 32'(datas[0]), 32'hC3);
    check("t2_data1", 32'(datas[1]), 32'h3C);
    check("t2_data2", 32'(datas[2]), 32'hA5);
    check("t2_data3", 32'(datas[3]), 32'h5A);
    check("t2_data4", 32'(datas[4]), 32'hC3);
    repeat (3) @(negedge clk);
    addr = '0;
    req = 4'b0001;
    @(negedge clk);
    check("t3_sel_at_grant", 32'({mux_s1, mux_s0}), 32'd0);
    addr[1:0] = 2'b11;
    collect(1, 1'b1, ids, stamps, datas);
    check("t3_rdata", 32'(datas[0]), 32'h3C);
    check("t3_sel_held", 32'({mux_s1, mux_s0}), 32'd0);
    repeat (3) @(negedge clk);
    addr = '0;
    req = 4'b1000;
    @(negedge clk);
    check("t4_in_sel", 32'(mux_e_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_e_n", 32'(mux_e_n), 32'd1);
    check("t4_async_rvalid", 32'(rvalid), 32'd0);
    check("t4_async_gnt", 32'(gnt), 32'd0);
    req = 4'b1001;
    extra = 0;
    repeat (3) begin @(negedge clk); extra += int'(rvalid) + int'(|gnt); end
    check("t4_no_pulse", 32'(extra), 32'd0);
    rst_n = 1'b1;
    collect(2, 1'b1, ids, stamps, datas);
    check("t4_first", 32'(ids[0]), 32'd0);
    check("t4_second", 32'(ids[1]), 32'd3);
    repeat (2) @(negedge clk);
    req = 4'b0001;
    collect(1, 1'b1, ids, stamps, datas);
    check("t5_prime", 32'(ids[0]), 32'd0);
    req = 4'b0101;
    collect(2, 1'b1, ids, stamps, datas);
    check("t5_rot_first", 32'(ids[0]), 32'd2);
    check("t5_rot_second", 32'(ids[1]), 32'd0);
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
